// File: rtl/pattern_line_arbiter.sv
// pattern_line_arbiter: two-requester round-robin arbiter that owns a single
// serial line `w` and shifts the winner's latched pattern out LSB-first, one
// bit every TICK_DIV clocks, then pulses done to the owner.
//
// Ports:
//   clk, rst_n    system clock, asynchronous active-low reset
//   req[1:0]      request level per requester
//   pat0, pat1    patterns (bit 0 sent first)
//   len0, len1    bit counts (clamped to PAT_W; zero completes immediately)
//   gnt[1:0]      one-hot line owner, held for the whole transfer
//   done[1:0]     one-cycle completion pulse to the owner
//   busy          high while shifting
//   w             serial pattern line, IDLE_LVL when no transfer is active
module pattern_line_arbiter #(
    parameter int unsigned TICK_DIV = 100000000,
    parameter int unsigned PAT_W    = 8,
    parameter logic        IDLE_LVL = 1'b0,
    parameter int unsigned LEN_W    = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req,
    input  logic [PAT_W-1:0] pat0,
    input  logic [PAT_W-1:0] pat1,
    input  logic [LEN_W-1:0] len0,
    input  logic [LEN_W-1:0] len1,
    output logic [1:0]       gnt,
    output logic [1:0]       done,
    output logic             busy,
    output logic             w
);

    localparam int unsigned      CNT_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [LEN_W-1:0] LEN_MAX   = LEN_W'(PAT_W);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [CNT_W-1:0]  r_cnt,   w_cnt_nxt;
    logic [LEN_W-1:0]  r_idx,   w_idx_nxt;
    logic [LEN_W-1:0]  r_len,   w_len_nxt;
    logic [PAT_W-1:0]  r_shreg, w_shreg_nxt;
    logic              r_last,  w_last_nxt;
    logic [1:0]        r_gnt,   w_gnt_nxt;
    logic [1:0]        r_done,  w_done_nxt;
    logic              r_busy,  w_busy_nxt;
    logic              r_w,     w_w_nxt;

    logic              w_any_req;
    logic              w_win;
    logic [1:0]        w_win_onehot;
    logic [PAT_W-1:0]  w_win_pat;
    logic [LEN_W-1:0]  w_win_len_raw;
    logic [LEN_W-1:0]  w_win_len;
    logic              w_tick_end;
    logic              w_last_bit;

    // Winner selection: a lone requester always wins; on contention the one
    // that did not own the line last time wins.
    assign w_any_req     = |req;
    assign w_win         = (req == 2'b11) ? ~r_last : req[1];
    assign w_win_onehot  = w_win ? 2'b10 : 2'b01;
    assign w_win_pat     = w_win ? pat1 : pat0;
    assign w_win_len_raw = w_win ? len1 : len0;
    assign w_win_len     = (w_win_len_raw > LEN_MAX) ? LEN_MAX : w_win_len_raw;

    assign w_tick_end    = (r_cnt == TICK_LAST);
    assign w_last_bit    = (r_idx == (r_len - LEN_W'(1)));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a zero-length grant never leaves IDLE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req && (w_win_len != '0)) begin
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_tick_end && w_last_bit) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Next values for the datapath and the registered outputs
    always_comb begin
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_len_nxt   = r_len;
        w_shreg_nxt = r_shreg;
        w_last_nxt  = r_last;
        w_gnt_nxt   = r_gnt;
        w_done_nxt  = 2'b00;
        w_busy_nxt  = r_busy;
        w_w_nxt     = r_w;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_last_nxt  = w_win;
                    w_len_nxt   = w_win_len;
                    w_shreg_nxt = w_win_pat;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    if (w_win_len != '0) begin
                        w_gnt_nxt  = w_win_onehot;
                        w_busy_nxt = 1'b1;
                        w_w_nxt    = w_win_pat[0];
                    end else begin
                        // Nothing to send: complete in place of the grant cycle
                        w_gnt_nxt  = 2'b00;
                        w_done_nxt = w_win_onehot;
                    end
                end
            end
            ST_SHIFT: begin
                if (w_tick_end) begin
                    w_cnt_nxt = '0;
                    if (w_last_bit) begin
                        w_gnt_nxt  = 2'b00;
                        w_done_nxt = r_gnt;
                        w_busy_nxt = 1'b0;
                        w_w_nxt    = IDLE_LVL;
                        w_idx_nxt  = '0;
                    end else begin
                        // Shift register keeps the next bit at position 0
                        w_idx_nxt   = r_idx + LEN_W'(1);
                        w_shreg_nxt = r_shreg >> 1;
                        w_w_nxt     = w_shreg_nxt[0];
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_len   <= '0;
            r_shreg <= '0;
            r_last  <= 1'b1;
            r_gnt   <= 2'b00;
            r_done  <= 2'b00;
            r_busy  <= 1'b0;
            r_w     <= IDLE_LVL;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_len   <= w_len_nxt;
            r_shreg <= w_shreg_nxt;
            r_last  <= w_last_nxt;
            r_gnt   <= w_gnt_nxt;
            r_done  <= w_done_nxt;
            r_busy  <= w_busy_nxt;
            r_w     <= w_w_nxt;
        end
    end

    assign gnt  = r_gnt;
    assign done = r_done;
    assign busy = r_busy;
    assign w    = r_w;

endmodule

// File: tb/tb_pattern_line_arbiter.sv
// Bench for pattern_line_arbiter (TICK_DIV=4, PAT_W=8, IDLE_LVL=0).
// Expected transfers are queued when stimulus is applied; a negedge monitor
// reconstructs each transfer from gnt/w/done and checks it against the queue.
module tb_pattern_line_arbiter;

    localparam int unsigned TD = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] req = 2'b00;
    logic [7:0] pat0 = 8'h00;
    logic [7:0] pat1 = 8'h00;
    logic [3:0] len0 = 4'd0;
    logic [3:0] len1 = 4'd0;
    logic [1:0] gnt;
    logic [1:0] done;
    logic       busy;
    logic       w;

    pattern_line_arbiter #(
        .TICK_DIV (TD),
        .PAT_W    (8),
        .IDLE_LVL (1'b0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .pat0  (pat0),
        .pat1  (pat1),
        .len0  (len0),
        .len1  (len1),
        .gnt   (gnt),
        .done  (done),
        .busy  (busy),
        .w     (w)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] req;
        logic [7:0] pat0;
        logic [7:0] pat1;
        logic [3:0] len0;
        logic [3:0] len1;
        logic [1:0] exp_owner;
        int         exp_bits;
        logic [7:0] exp_pat;
    } vec_t;

    typedef struct {
        logic [1:0] owner;
        int         nbits;
        logic [7:0] pat;
        bit         chk_gap;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   ndone = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
        checks++;
        if (act !== req_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req_v, cyc);
        end
    endtask

    // Monitor: rebuilds each transfer and compares it at the done pulse
    logic [1:0] prev_gnt = 2'b00;
    logic [1:0] cur_owner = 2'b00;
    logic [7:0] cap = 8'h00;
    int         cur_cycles = 0;
    int         cur_rise = 0;
    int         prev_done = -10;

    always @(negedge clk) begin : mon
        int         bi;
        exp_t       e;
        logic [7:0] mask;
        cyc++;
        if (!rst_n) begin
            cur_cycles = 0;
            cap        = 8'h00;
            prev_gnt   = 2'b00;
        end else begin
            chk("gnt_not_both", 32'(gnt == 2'b11), 32'd0);
            chk("busy_vs_gnt", 32'(busy), 32'(gnt != 2'b00));
            if (gnt == 2'b00) chk("w_idle_level", 32'(w), 32'd0);
            if (gnt != 2'b00) begin
                if (prev_gnt == 2'b00) begin
                    cur_rise  = cyc;
                    cur_owner = gnt;
                end else begin
                    chk("gnt_held", 32'(gnt), 32'(cur_owner));
                end
                bi = cur_cycles / TD;
                if (bi < 8) begin
                    if ((cur_cycles % TD) == 0) cap[bi] = w;
                    else chk("w_bit_hold", 32'(w), 32'(cap[bi]));
                end
                cur_cycles++;
            end
            if (done != 2'b00) begin
                ndone++;
                chk("done_one_cycle", 32'((cyc - prev_done) > 1), 32'd1);
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=%b with empty queue (cycle %0d)", done, cyc);
                end else begin
                    e    = sbq.pop_front();
                    mask = 8'((32'd1 << e.nbits) - 32'd1);
                    chk("done_owner", 32'(done), 32'(e.owner));
                    chk("xfer_cycles", 32'(cur_cycles), 32'(e.nbits * TD));
                    chk("xfer_bits", 32'(cap & mask), 32'(e.pat & mask));
                    if (e.chk_gap) chk("idle_gap", 32'(cur_rise - prev_done), 32'd1);
                end
                prev_done  = cyc;
                cur_cycles = 0;
                cap        = 8'h00;
            end
            prev_gnt = gnt;
        end
    end

    // Wait (bounded) until the monitor has counted `target` done pulses
    task automatic wait_done(input int target, input string name);
        int k;
        for (k = 0; k < 100; k++) begin
            if (ndone >= target) break;
            @(negedge clk);
            #1;
        end
        chk({name, "_timeout"}, 32'(ndone >= target), 32'd1);
    endtask

    // One-cycle request pulse, then check grant latency and completion
    task automatic apply(input vec_t v);
        exp_t e;
        int   n0;
        e.owner   = v.exp_owner;
        e.nbits   = v.exp_bits;
        e.pat     = v.exp_pat;
        e.chk_gap = 1'b0;
        n0        = ndone;
        @(negedge clk);
        pat0 = v.pat0;
        pat1 = v.pat1;
        len0 = v.len0;
        len1 = v.len1;
        req  = v.req;
        sbq.push_back(e);
        @(negedge clk);
        req = 2'b00;
        if (v.exp_bits > 0) begin
            chk("first_gnt", 32'(gnt), 32'(v.exp_owner));
            chk("first_bit", 32'(w), 32'(v.exp_pat[0]));
            chk("busy_on", 32'(busy), 32'd1);
        end else begin
            chk("zero_len_done", 32'(done), 32'(v.exp_owner));
        end
        #1;
        wait_done(n0 + 1, "vec");
    endtask

    vec_t vecs[10];

    initial begin : stim
        exp_t e;
        int   n0;
        int   k;

        vecs[0] = '{2'b11, 8'hA5, 8'h3C, 4'd3,  4'd5, 2'b01, 3, 8'hA5};
        vecs[1] = '{2'b01, 8'h1E, 8'h00, 4'd6,  4'd0, 2'b01, 6, 8'h1E};
        vecs[2] = '{2'b11, 8'hFF, 8'h96, 4'd2,  4'd8, 2'b10, 8, 8'h96};
        vecs[3] = '{2'b10, 8'h00, 8'h5A, 4'd0,  4'd0, 2'b10, 0, 8'h00};
        vecs[4] = '{2'b11, 8'hC3, 8'h11, 4'd15, 4'd3, 2'b01, 8, 8'hC3};
        vecs[5] = '{2'b10, 8'h00, 8'h01, 4'd2,  4'd1, 2'b10, 1, 8'h01};
        vecs[6] = '{2'b11, 8'hFF, 8'hFF, 4'd0,  4'd4, 2'b01, 0, 8'h00};
        vecs[7] = '{2'b11, 8'h77, 8'h0B, 4'd3,  4'd4, 2'b10, 4, 8'h0B};
        vecs[8] = '{2'b01, 8'h80, 8'h00, 4'd8,  4'd0, 2'b01, 8, 8'h80};
        vecs[9] = '{2'b10, 8'h00, 8'h7E, 4'd0,  4'd9, 2'b10, 8, 8'h7E};

        // Reset held with both requesting
        req = 2'b11;
        repeat (3) @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_w", 32'(w), 32'd0);
        req   = 2'b00;
        rst_n = 1'b1;

        // Table of single transfers (vec0 checks requester 0 wins first)
        for (int i = 0; i < 10; i++) apply(vecs[i]);

        // Pattern and len change plus req drop mid-transfer: latched data is sent
        n0 = ndone;
        @(negedge clk);
        e = '{2'b01, 8, 8'hCA, 1'b0};
        sbq.push_back(e);
        pat0 = 8'hCA;
        len0 = 4'd8;
        req  = 2'b01;
        repeat (6) @(negedge clk);
        pat0 = 8'h35;
        len0 = 4'd2;
        req  = 2'b00;
        #1;
        wait_done(n0 + 1, "latched");

        // Reset during bit 3 of a transfer: abort, no done
        n0 = ndone;
        @(negedge clk);
        pat0 = 8'hFF;
        len0 = 4'd8;
        req  = 2'b01;
        @(negedge clk);
        req = 2'b00;
        repeat (13) @(negedge clk);
        chk("pre_abort_w", 32'(w), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_gnt", 32'(gnt), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_w", 32'(w), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        chk("abort_no_done", 32'(ndone), 32'(n0));

        // Continuous contention: 0,1,0,1 with one idle cycle between transfers
        n0 = ndone;
        for (int i = 0; i < 4; i++) begin
            e.owner   = (i % 2 == 0) ? 2'b01 : 2'b10;
            e.nbits   = 2;
            e.pat     = (i % 2 == 0) ? 8'h02 : 8'h01;
            e.chk_gap = (i != 0);
            sbq.push_back(e);
        end
        @(negedge clk);
        pat0 = 8'h02;
        pat1 = 8'h01;
        len0 = 4'd2;
        len1 = 4'd2;
        req  = 2'b11;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            #1;
            if (ndone - n0 >= 4) break;
        end
        req = 2'b00;
        chk("contention_dones", 32'(ndone - n0), 32'd4);
        repeat (3) @(negedge clk);
        chk("contention_quiet", 32'(gnt), 32'd0);
        chk("queue_empty", 32'(sbq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d expected < 100000", cyc);
        $fatal(1);
    end

endmodule
